pc_fetch_gen: RTL and testbench

Parametrised program-counter generator. It replaces the single-outstanding PC register with a fetch-request handshake toward the memory controller. It supports up to MAX_INFLIGHT outstanding instruction fetches and discards stale responses after a redirect. It sits between the jump/branch resolution logic and MEMCTRL, and feeds IF with the fetch PC and a filtered instruction-valid strobe.

---
 rtl/pc_fetch_gen_pkg.sv | 10 +
 rtl/pc_inflight_ctr.sv | 45 ++++
 rtl/pc_fetch_gen.sv | 98 +++++++++
 tb/tb_pc_fetch_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_gen_pkg.sv
// Shared constants for the fetch PC generator: default address width,
// default reset PC and single-bit enable/disable levels.
package pc_fetch_gen_pkg;

    localparam int                 AddrLen   = 32;
    localparam logic [AddrLen-1:0] ZERO_WORD = '0;
    localparam logic               Enable    = 1'b1;
    localparam logic               Disable   = 1'b0;

endpackage

// File: rtl/pc_inflight_ctr.sv
// Saturating up/down counter with synchronous load and a global hold enable.
// Counts clamp at 0 and MAX_VAL; simultaneous inc and dec cancel.
module pc_inflight_ctr #(
    parameter int W       = 2,
    parameter int MAX_VAL = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MaxCnt = W'(MAX_VAL);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (load) begin
                cnt_d = load_val;
            end else if (inc && !dec && cnt_q != MaxCnt) begin
                cnt_d = cnt_q + W'(1);
            end else if (dec && !inc && cnt_q != '0) begin
                cnt_d = cnt_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_fetch_gen.sv
// Program-counter generator issuing pipelined fetch requests to MEMCTRL and
// filtering out responses that belong to a path abandoned by a redirect.
module pc_fetch_gen
    import pc_fetch_gen_pkg::*;
#(
    parameter int                ADDR_W       = AddrLen,
    parameter logic [ADDR_W-1:0] RESET_PC     = ADDR_W'(ZERO_WORD),
    parameter int                STEP         = 4,
    parameter int                MAX_INFLIGHT = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  rdy,
    input  logic                                  stall_i,
    input  logic                                  redirect_valid_i,
    input  logic [ADDR_W-1:0]                     redirect_pc_i,
    output logic                                  fetch_req_o,
    output logic [ADDR_W-1:0]                     fetch_pc_o,
    input  logic                                  fetch_gnt_i,
    input  logic                                  fetch_rsp_valid_i,
    output logic                                  inst_valid_o,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight_o
);

    localparam int                CW        = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0]     MaxCnt    = CW'(MAX_INFLIGHT);
    localparam logic [ADDR_W-1:0] StepInc   = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] AlignMask = ~(StepInc - ADDR_W'(1));

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     discard;
    logic [CW-1:0]     discard_load;
    logic              active;
    logic              redirect;
    logic              rsp;
    logic              grant;

    always_comb begin
        active       = rdy & ~rst;
        redirect     = active & redirect_valid_i;
        rsp          = active & fetch_rsp_valid_i;
        fetch_req_o  = active & ~stall_i & ~redirect_valid_i & (inflight < MaxCnt);
        grant        = fetch_req_o & fetch_gnt_i;
        // A response with nothing outstanding is a protocol error and is never delivered.
        inst_valid_o = rsp & ~redirect & (inflight != '0) & (discard == '0);
        discard_load = (inflight != '0) ? inflight - CW'(rsp) : '0;

        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc_i & AlignMask;
        end else if (grant) begin
            pc_d = pc_q + StepInc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    pc_inflight_ctr #(
        .W       (CW),
        .MAX_VAL (MAX_INFLIGHT)
    ) u_inflight_ctr (
        .clk      (clk),
        .rst      (rst),
        .en       (rdy),
        .load     (Disable),
        .load_val ('0),
        .inc      (grant),
        .dec      (rsp),
        .cnt_o    (inflight)
    );

    // Responses still owed for the old path are dropped one by one as they arrive.
    pc_inflight_ctr #(
        .W       (CW),
        .MAX_VAL (MAX_INFLIGHT)
    ) u_discard_ctr (
        .clk      (clk),
        .rst      (rst),
        .en       (rdy),
        .load     (redirect),
        .load_val (discard_load),
        .inc      (Disable),
        .dec      (rsp),
        .cnt_o    (discard)
    );

    assign fetch_pc_o = pc_q;
    assign inflight_o = inflight;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed bench for pc_fetch_gen with default parameters (32-bit, STEP 4,
// two outstanding fetches); expected values are hand-computed per cycle.
module tb_pc_fetch_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        fetch_req_o;
    logic [31:0] fetch_pc_o;
    logic        fetch_gnt_i;
    logic        fetch_rsp_valid_i;
    logic        inst_valid_o;
    logic [1:0]  inflight_o;

    int checks = 0;
    int errors = 0;

    pc_fetch_gen dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .stall_i           (stall_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_pc_i     (redirect_pc_i),
        .fetch_req_o       (fetch_req_o),
        .fetch_pc_o        (fetch_pc_o),
        .fetch_gnt_i       (fetch_gnt_i),
        .fetch_rsp_valid_i (fetch_rsp_valid_i),
        .inst_valid_o      (inst_valid_o),
        .inflight_o        (inflight_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Registered state right after an edge.
    task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] inf);
        check_eq({tag, "_pc"}, fetch_pc_o, pc);
        check_eq({tag, "_inflight"}, 32'(inflight_o), inf);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; stall_i = 1'b0; redirect_valid_i = 1'b0;
        redirect_pc_i = '0; fetch_gnt_i = 1'b0; fetch_rsp_valid_i = 1'b0;
        tick();
        fetch_rsp_valid_i = 1'b1; fetch_gnt_i = 1'b1; #1;
        check_eq("rst_req", 32'(fetch_req_o), 0);
        check_eq("rst_ival", 32'(inst_valid_o), 0);
        tick();
        check_state("rst", 32'h0, 0);

        // Free run, responses arriving two cycles after each grant
        rst = 1'b0; fetch_rsp_valid_i = 1'b0; fetch_gnt_i = 1'b1; #1;
        check_eq("run0_req", 32'(fetch_req_o), 1);
        tick();
        check_state("run1", 32'h4, 1);
        check_eq("run1_req", 32'(fetch_req_o), 1);
        tick();
        check_state("run2", 32'h8, 2);
        check_eq("run2_req_full", 32'(fetch_req_o), 0);
        fetch_rsp_valid_i = 1'b1; #1;
        check_eq("run2_ival", 32'(inst_valid_o), 1);
        tick();
        check_state("run3", 32'h8, 1);
        check_eq("run3_req", 32'(fetch_req_o), 1);
        check_eq("run3_ival", 32'(inst_valid_o), 1);
        tick();
        check_state("run4", 32'hC, 1);
        check_eq("run4_ival", 32'(inst_valid_o), 1);
        tick();
        check_state("run5", 32'h10, 1);
        fetch_rsp_valid_i = 1'b0;
        tick();
        check_state("run6", 32'h14, 2);

        // Redirect with two outstanding
        fetch_gnt_i = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 32'h103; #1;
        check_eq("redir_req", 32'(fetch_req_o), 0);
        tick();
        redirect_valid_i = 1'b0;
        check_state("redir", 32'h100, 2);
        check_eq("redir_discard", 32'(dut.u_discard_ctr.cnt_o), 2);
        fetch_rsp_valid_i = 1'b1; #1;
        check_eq("drop1_ival", 32'(inst_valid_o), 0);
        check_eq("drop1_req", 32'(fetch_req_o), 0);
        tick();
        check_eq("drop1_inflight", 32'(inflight_o), 1);
        check_eq("drop1_discard", 32'(dut.u_discard_ctr.cnt_o), 1);
        fetch_gnt_i = 1'b1; #1;
        check_eq("drop2_req", 32'(fetch_req_o), 1);
        check_eq("drop2_ival", 32'(inst_valid_o), 0);
        tick();
        check_state("newpath", 32'h104, 1);
        check_eq("newpath_discard", 32'(dut.u_discard_ctr.cnt_o), 0);
        fetch_gnt_i = 1'b0; #1;
        check_eq("newpath_ival", 32'(inst_valid_o), 1);
        tick();
        check_eq("newpath_drain", 32'(inflight_o), 0);

        // Redirect coincident with a response, two outstanding
        fetch_rsp_valid_i = 1'b0; fetch_gnt_i = 1'b1;
        tick();
        tick();
        check_state("co_fill", 32'h10C, 2);
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h200; fetch_rsp_valid_i = 1'b1; #1;
        check_eq("co_req", 32'(fetch_req_o), 0);
        check_eq("co_ival", 32'(inst_valid_o), 0);
        tick();
        redirect_valid_i = 1'b0; fetch_gnt_i = 1'b0;
        check_state("co", 32'h200, 1);
        check_eq("co_discard", 32'(dut.u_discard_ctr.cnt_o), 1);
        #1;
        check_eq("co_drop_ival", 32'(inst_valid_o), 0);
        check_eq("co_drop_req", 32'(fetch_req_o), 1);
        tick();
        check_eq("co_drain", 32'(inflight_o), 0);
        check_eq("co_drain_discard", 32'(dut.u_discard_ctr.cnt_o), 0);

        // Stall with one outstanding, then redirect while stalled
        fetch_rsp_valid_i = 1'b0; fetch_gnt_i = 1'b1;
        tick();
        check_state("st0", 32'h204, 1);
        stall_i = 1'b1; #1;
        check_eq("st0_req", 32'(fetch_req_o), 0);
        tick();
        check_state("st1", 32'h204, 1);
        fetch_rsp_valid_i = 1'b1; #1;
        check_eq("st1_ival", 32'(inst_valid_o), 1);
        check_eq("st1_req", 32'(fetch_req_o), 0);
        tick();
        check_eq("st2_inflight", 32'(inflight_o), 0);
        fetch_rsp_valid_i = 1'b0; redirect_valid_i = 1'b1; redirect_pc_i = 32'h305;
        tick();
        redirect_valid_i = 1'b0; stall_i = 1'b0;
        check_state("st_redir", 32'h304, 0);
        #1;
        check_eq("st_release_req", 32'(fetch_req_o), 1);

        // rdy low freezes everything, then wrap at the top of the address space
        tick();
        check_state("rdy0", 32'h308, 1);
        rdy = 1'b0; fetch_rsp_valid_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h0; #1;
        check_eq("rdy_req", 32'(fetch_req_o), 0);
        check_eq("rdy_ival", 32'(inst_valid_o), 0);
        tick();
        check_state("rdy1", 32'h308, 1);
        tick();
        check_state("rdy2", 32'h308, 1);
        rdy = 1'b1; fetch_gnt_i = 1'b0; redirect_pc_i = 32'hFFFF_FFFC; #1;
        check_eq("rdy_back_ival", 32'(inst_valid_o), 0);
        tick();
        redirect_valid_i = 1'b0; fetch_rsp_valid_i = 1'b0; fetch_gnt_i = 1'b1;
        check_state("wrap0", 32'hFFFF_FFFC, 0);
        check_eq("wrap0_discard", 32'(dut.u_discard_ctr.cnt_o), 0);
        #1;
        check_eq("wrap0_req", 32'(fetch_req_o), 1);
        tick();
        check_state("wrap1", 32'h0, 1);
        fetch_gnt_i = 1'b0; fetch_rsp_valid_i = 1'b1; #1;
        check_eq("wrap1_ival", 32'(inst_valid_o), 1);
        tick();

        // Spurious grant and response with nothing outstanding
        fetch_rsp_valid_i = 1'b0; stall_i = 1'b1; fetch_gnt_i = 1'b1; #1;
        check_eq("spur_req", 32'(fetch_req_o), 0);
        tick();
        check_state("spur_gnt", 32'h0, 0);
        fetch_gnt_i = 1'b0; fetch_rsp_valid_i = 1'b1; #1;
        check_eq("spur_rsp_ival", 32'(inst_valid_o), 0);
        tick();
        check_state("spur_rsp", 32'h0, 0);
        check_eq("spur_discard", 32'(dut.u_discard_ctr.cnt_o), 0);

        // Reset in the middle of traffic
        stall_i = 1'b0; fetch_rsp_valid_i = 1'b0; fetch_gnt_i = 1'b1;
        tick();
        check_state("mid0", 32'h4, 1);
        rst = 1'b1; #1;
        check_eq("mid_rst_req", 32'(fetch_req_o), 0);
        tick();
        check_state("mid_rst", 32'h0, 0);
        rst = 1'b0; fetch_gnt_i = 1'b0; #1;
        check_eq("mid_first_req", 32'(fetch_req_o), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
